// File: rtl/counter_bus_pkg.sv
// Shared definitions for the counter bus master: register addresses,
// FSM state encoding and the default data bus width.
package counter_bus_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ADDR_PLR = 2'b00;
    localparam logic [1:0] ADDR_ULR = 2'b01;
    localparam logic [1:0] ADDR_LLR = 2'b10;
    localparam logic [1:0] ADDR_CCR = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/counter_bus_master_if.sv
// Command/response handshake between a host and counter_bus_master.
// The host side uses the master modport, the bus master itself the slave one.
interface counter_bus_master_if
    import counter_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

endinterface

// File: rtl/counter_init_seq.sv
// Lookup of the four power-up register writes (PLR, ULR, LLR, CCR in order).
// Only built when COUNTER_BUS_AUTO_INIT_EN is defined.
`ifdef COUNTER_BUS_AUTO_INIT_EN
module counter_init_seq
    import counter_bus_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int INIT_PLR = 10,
    parameter int INIT_ULR = 15,
    parameter int INIT_LLR = 5,
    parameter int INIT_CCR = 2
)(
    input  logic [1:0]        idx,
    output logic [1:0]        addr,
    output logic [DATA_W-1:0] data
);

    // Map the sequence index onto the register address and its init value
    always_comb begin
        addr = ADDR_PLR;
        data = DATA_W'(INIT_PLR);
        case (idx)
            2'd0: begin addr = ADDR_PLR; data = DATA_W'(INIT_PLR); end
            2'd1: begin addr = ADDR_ULR; data = DATA_W'(INIT_ULR); end
            2'd2: begin addr = ADDR_LLR; data = DATA_W'(INIT_LLR); end
            default: begin addr = ADDR_CCR; data = DATA_W'(INIT_CCR); end
        endcase
    end

endmodule
`endif

// File: rtl/counter_bus_master.sv
// Bus initiator for the up_down_counter register file. Turns valid/ready
// commands into SETUP / STROBE / HOLD / DONE strobe-bus cycles.
// Optional power-up register programming: COUNTER_BUS_AUTO_INIT_EN.
module counter_bus_master
    import counter_bus_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STROBE_CYC = 2,
    parameter int INIT_PLR   = 10,
    parameter int INIT_ULR   = 15,
    parameter int INIT_LLR   = 5,
    parameter int INIT_CCR   = 2
)(
    input  logic                clk,
    input  logic                reset,
    counter_bus_master_if.slave cmd,
    inout  wire  [DATA_W-1:0]   din,
    output logic                ncs,
    output logic                nrd,
    output logic                nwr,
    output logic                A1,
    output logic                A0,
    input  logic                err
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

`ifdef COUNTER_BUS_AUTO_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t            state;
    state_t            next_state;
    logic [3:0]        strobe_cnt;
    logic              lat_write;
    logic [1:0]        lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              init_done_q;
    logic              ready;
    logic              rsp_pulse;
    logic              drive_en;
    logic              accept;
    logic              last_strobe;

`ifdef COUNTER_BUS_AUTO_INIT_EN
    logic [1:0]        init_idx;
    logic [1:0]        init_addr;
    logic [DATA_W-1:0] init_data;

    counter_init_seq #(
        .DATA_W   (DATA_W),
        .INIT_PLR (INIT_PLR),
        .INIT_ULR (INIT_ULR),
        .INIT_LLR (INIT_LLR),
        .INIT_CCR (INIT_CCR)
    ) u_init_seq (
        .idx  (init_idx),
        .addr (init_addr),
        .data (init_data)
    );
`endif

    assign accept      = cmd.cmd_valid && ready;
    assign last_strobe = (state == ST_STROBE) && (strobe_cnt == 4'd0);

    // State register; reset abandons any bus cycle in progress
    always_ff @(posedge clk) begin
        if (!reset) state <= RESET_STATE;
        else        state <= next_state;
    end

    // Next-state logic: one SETUP, STROBE_CYC strobe cycles, HOLD, then DONE
    always_comb begin
        next_state = state;
        case (state)
`ifdef COUNTER_BUS_AUTO_INIT_EN
            ST_INIT:   next_state = ST_SETUP;
`endif
            ST_IDLE:   if (accept) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_STROBE;
            ST_STROBE: if (strobe_cnt == 4'd0) next_state = ST_HOLD;
            ST_HOLD:   next_state = ST_DONE;
            ST_DONE: begin
                next_state = ST_IDLE;
`ifdef COUNTER_BUS_AUTO_INIT_EN
                if (!init_done_q && init_idx != 2'd3) next_state = ST_INIT;
`endif
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from the current state
    always_comb begin
        ncs       = 1'b1;
        nrd       = 1'b1;
        nwr       = 1'b1;
        {A1, A0}  = 2'b00;
        drive_en  = 1'b0;
        ready     = 1'b0;
        rsp_pulse = 1'b0;
        case (state)
            ST_IDLE: ready = init_done_q;
            ST_SETUP, ST_HOLD: begin
                ncs      = 1'b0;
                {A1, A0} = lat_addr;
                drive_en = lat_write;
            end
            ST_STROBE: begin
                ncs      = 1'b0;
                {A1, A0} = lat_addr;
                drive_en = lat_write;
                nwr      = !lat_write;
                nrd      = lat_write;
            end
            ST_DONE: rsp_pulse = init_done_q;
            default: ;
        endcase
    end

    assign din = drive_en ? lat_wdata : {DATA_W{1'bz}};

    assign cmd.cmd_ready = ready;
    assign cmd.rsp_valid = rsp_pulse;
    assign cmd.rsp_rdata = rsp_rdata_q;
    assign cmd.rsp_err   = rsp_err_q;
    assign cmd.init_done = init_done_q;

    // Command latch, strobe timer, response capture and init bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            strobe_cnt  <= 4'd0;
            lat_write   <= 1'b0;
            lat_addr    <= 2'b00;
            lat_wdata   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
`ifdef COUNTER_BUS_AUTO_INIT_EN
            init_idx    <= 2'd0;
`endif
        end else begin
            if (accept) begin
                lat_write <= cmd.cmd_write;
                lat_addr  <= cmd.cmd_addr;
                lat_wdata <= cmd.cmd_wdata;
            end
`ifdef COUNTER_BUS_AUTO_INIT_EN
            if (state == ST_INIT) begin
                lat_write <= 1'b1;
                lat_addr  <= init_addr;
                lat_wdata <= init_data;
            end
            if (state == ST_DONE && !init_done_q) init_idx <= init_idx + 2'd1;
            if (state == ST_DONE && next_state == ST_IDLE) init_done_q <= 1'b1;
`else
            init_done_q <= 1'b1;
`endif
            if (state == ST_SETUP)
                strobe_cnt <= STROBE_LOAD;
            else if (state == ST_STROBE && strobe_cnt != 4'd0)
                strobe_cnt <= strobe_cnt - 4'd1;
            if (last_strobe) begin
                rsp_rdata_q <= lat_write ? '0 : din;
                rsp_err_q   <= err;
            end
        end
    end

endmodule
